// File: rtl/arb_mon_pkg.sv
// Shared types for the arbiter protocol monitor: error codes, channel FSM states
// and counter width default.
package arb_mon_pkg;

  localparam int NUM_ERR   = 6;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    E_RSTGNT  = 3'd0,
    E_ONEHOT  = 3'd1,
    E_NOREQ   = 3'd2,
    E_SHORT   = 3'd3,
    E_OVERRUN = 3'd4,
    E_STARVE  = 3'd5
  } err_code_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_FREE = 2'd2
  } chan_state_e;

endpackage

// File: rtl/arb_mon_chan.sv
// Per-channel grant-hold FSM, starvation counter and optional completed-grant
// counter (built only with ARB_MON_COVER_EN). Error flags refer to the current sampled cycle.
module arb_mon_chan
  import arb_mon_pkg::*;
#(
  parameter int GRANT_LEN    = 16,
  parameter int STARVE_LIMIT = 64,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             gnt,
  input  logic             other_req,
  output logic             noreq_err,
  output logic             short_err,
  output logic             overrun_err,
  output logic             starve_err,
  output logic [CNT_W-1:0] cov
);

  localparam int RUN_W = $clog2(GRANT_LEN + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(GRANT_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE  = {{(RUN_W-1){1'b0}}, 1'b1};
  localparam logic [RUN_W-1:0] RUN_ZERO = {RUN_W{1'b0}};
  localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_LIMIT);
  localparam logic [ST_W-1:0]  ST_ONE   = {{(ST_W-1){1'b0}}, 1'b1};
  localparam logic [ST_W-1:0]  ST_ZERO  = {ST_W{1'b0}};

  chan_state_e      state_r, state_s;
  logic [RUN_W-1:0] run_r, run_s;
  logic [ST_W-1:0]  st_r, st_s;
  logic             ovr_done_r, ovr_done_s;
  logic             done_s;

  // State register: FSM, run length, overrun-reported flag, starvation count
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      run_r      <= RUN_ZERO;
      st_r       <= ST_ZERO;
      ovr_done_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      run_r      <= run_s;
      st_r       <= st_s;
      ovr_done_r <= ovr_done_s;
    end
  end

  // Next-state logic for the grant FSM and the starvation counter
  always_comb begin
    state_s    = state_r;
    run_s      = run_r;
    ovr_done_s = ovr_done_r;
    done_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (gnt) begin
          run_s      = RUN_ONE;
          state_s    = (RUN_ONE == RUN_MAX) ? S_FREE : S_HOLD;
          ovr_done_s = 1'b0;
        end else begin
          run_s = RUN_ZERO;
        end
      end
      S_HOLD: begin
        if (gnt) begin
          run_s = run_r + RUN_ONE;
          if (run_s == RUN_MAX) begin
            state_s = S_FREE;
          end else begin
            state_s = S_HOLD;
          end
        end else begin
          state_s = S_IDLE;
          run_s   = RUN_ZERO;
        end
      end
      S_FREE: begin
        if (!gnt) begin
          state_s    = S_IDLE;
          run_s      = RUN_ZERO;
          ovr_done_s = 1'b0;
          done_s     = 1'b1;
        end else if (other_req) begin
          ovr_done_s = 1'b1;
        end else begin
          ovr_done_s = ovr_done_r;
        end
      end
      default: begin
        state_s    = S_IDLE;
        run_s      = RUN_ZERO;
        ovr_done_s = 1'b0;
      end
    endcase

    if (req && !gnt) begin
      if (st_r != ST_MAX) begin
        st_s = st_r + ST_ONE;
      end else begin
        st_s = st_r;
      end
    end else begin
      st_s = ST_ZERO;
    end
  end

  // Error flags decoded from current state and sampled inputs
  always_comb begin
    noreq_err   = gnt & ~req;
    short_err   = (state_r == S_HOLD) & ~gnt & req;
    overrun_err = (state_r == S_FREE) & gnt & other_req & ~ovr_done_r;
    starve_err  = (st_s == ST_MAX) & (st_r != ST_MAX);
  end

`ifdef ARB_MON_COVER_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] cov_r;

  // Saturating count of grants that ran to full length and were released
  always_ff @(posedge clk) begin
    if (!reset) begin
      cov_r <= {CNT_W{1'b0}};
    end else if (done_s && (cov_r != CNT_MAX)) begin
      cov_r <= cov_r + CNT_ONE;
    end else begin
      cov_r <= cov_r;
    end
  end

  assign cov = cov_r;
`else
  logic unused_done_s;
  assign unused_done_s = done_s;
  assign cov           = {CNT_W{1'b0}};
`endif

endmodule

// File: rtl/arb_protocol_monitor.sv
// Passive req/gnt protocol monitor for an N-requester grant-hold arbiter.
// Define ARB_MON_COVER_EN to build the per-channel completed-grant counters on gnt_cov.
module arb_protocol_monitor
  import arb_mon_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int GRANT_LEN    = 16,
  parameter int STARVE_LIMIT = 64,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         gnt,
  output logic                     err_valid,
  output logic [2:0]               err_code,
  output logic [$clog2(N_REQ)-1:0] err_chan,
  output logic [NUM_ERR-1:0]       err_sticky,
  output logic [CNT_W-1:0]         err_count,
  output logic [N_REQ*CNT_W-1:0]   gnt_cov
);

  localparam int CH_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE_VEC = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CH_W-1:0] first_chan(input logic [N_REQ-1:0] v);
    logic [CH_W-1:0] idx;
    logic            found;
    idx   = {CH_W{1'b0}};
    found = 1'b0;
    for (int k = 32'sd0; k < N_REQ; k++) begin
      if (v[k] && !found) begin
        idx   = CH_W'(k);
        found = 1'b1;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic                 rst_exit_r;
  logic [N_REQ-1:0]     other_req_s, noreq_s, short_s, overrun_s, starve_s;
  logic [CNT_W-1:0]     cov_s [N_REQ];
  logic [NUM_ERR-1:0]   err_vec_s;
  logic                 multi_gnt_s;
  err_code_e            code_s;
  logic [CH_W-1:0]      chan_s;

  for (genvar g = 0; g < N_REQ; g++) begin : g_chan
    assign other_req_s[g] = |(req & ~(ONE_VEC << g));

    arb_mon_chan #(
      .GRANT_LEN   (GRANT_LEN),
      .STARVE_LIMIT(STARVE_LIMIT),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .req        (req[g]),
      .gnt        (gnt[g]),
      .other_req  (other_req_s[g]),
      .noreq_err  (noreq_s[g]),
      .short_err  (short_s[g]),
      .overrun_err(overrun_s[g]),
      .starve_err (starve_s[g]),
      .cov        (cov_s[g])
    );

    assign gnt_cov[g*CNT_W +: CNT_W] = cov_s[g];
  end

  // x & (x-1) is non-zero exactly when more than one bit of x is set
  assign multi_gnt_s = |(gnt & (gnt - ONE_VEC));
  assign err_vec_s   = {|starve_s, |overrun_s, |short_s, |noreq_s, multi_gnt_s,
                        rst_exit_r & (|gnt)};

  // Priority encode: lowest code wins, lowest channel within a code
  always_comb begin
    code_s = E_RSTGNT;
    chan_s = {CH_W{1'b0}};
    if (err_vec_s[0]) begin
      code_s = E_RSTGNT;
    end else if (err_vec_s[1]) begin
      code_s = E_ONEHOT;
    end else if (err_vec_s[2]) begin
      code_s = E_NOREQ;
      chan_s = first_chan(noreq_s);
    end else if (err_vec_s[3]) begin
      code_s = E_SHORT;
      chan_s = first_chan(short_s);
    end else if (err_vec_s[4]) begin
      code_s = E_OVERRUN;
      chan_s = first_chan(overrun_s);
    end else if (err_vec_s[5]) begin
      code_s = E_STARVE;
      chan_s = first_chan(starve_s);
    end else begin
      code_s = E_RSTGNT;
      chan_s = {CH_W{1'b0}};
    end
  end

  // Output registers and reset-exit tracking
  always_ff @(posedge clk) begin
    if (!reset) begin
      rst_exit_r <= 1'b1;
      err_valid  <= 1'b0;
      err_code   <= 3'd0;
      err_chan   <= {CH_W{1'b0}};
      err_sticky <= {NUM_ERR{1'b0}};
      err_count  <= {CNT_W{1'b0}};
    end else begin
      rst_exit_r <= 1'b0;
      err_valid  <= |err_vec_s;
      err_code   <= code_s;
      err_chan   <= chan_s;
      err_sticky <= err_sticky | err_vec_s;
      if ((|err_vec_s) && (err_count != CNT_MAX)) begin
        err_count <= err_count + CNT_ONE;
      end else begin
        err_count <= err_count;
      end
    end
  end

endmodule

// File: tb/tb_arb_protocol_monitor.sv
// Self-checking bench for arb_protocol_monitor: table vectors plus multi-cycle sequences.
module tb_arb_protocol_monitor;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [1:0]  err_chan;
  logic [5:0]  err_sticky;
  logic [15:0] err_count;
  logic [63:0] gnt_cov;

  arb_protocol_monitor #(
    .N_REQ(4), .GRANT_LEN(16), .STARVE_LIMIT(64), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt),
    .err_valid(err_valid), .err_code(err_code), .err_chan(err_chan),
    .err_sticky(err_sticky), .err_count(err_count), .gnt_cov(gnt_cov)
  );

  localparam logic [5:0] M_NONE  = 6'b000000;
  localparam logic [5:0] M_RST   = 6'b000001;
  localparam logic [5:0] M_ONE   = 6'b000010;
  localparam logic [5:0] M_NOREQ = 6'b000100;
  localparam logic [5:0] M_SHORT = 6'b001000;
  localparam logic [5:0] M_OVR   = 6'b010000;
  localparam logic [5:0] M_STV   = 6'b100000;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [5:0] errs;
    logic [1:0] chan;
  } vec_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  code;
    logic [1:0]  chan;
    logic [5:0]  sticky;
    logic [15:0] count;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs [14];
  logic [5:0]  exp_sticky;
  logic [15:0] exp_count;
  logic [15:0] exp_cov [4];
  int          checks;
  int          errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic cmp(input string name, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", name, what, act, exp);
    end
  endtask

  task automatic check_out(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      cmp(name, "err_valid", 32'(err_valid), 32'(e.valid));
      if (e.valid) begin
        cmp(name, "err_code", 32'(err_code), 32'(e.code));
        cmp(name, "err_chan", 32'(err_chan), 32'(e.chan));
      end
      cmp(name, "err_sticky", 32'(err_sticky), 32'(e.sticky));
      cmp(name, "err_count", 32'(err_count), 32'(e.count));
    end
  endtask

  // Drive one sampled cycle (called at a falling edge), push the expected result, check it next fall.
  task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] g,
                      input logic [5:0] errs, input logic [1:0] ch, input string name);
    exp_t e;
    reset = rst;
    req   = r;
    gnt   = g;
    e.valid = rst && (errs != M_NONE);
    e.code  = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (errs[k]) e.code = 3'(k);
    end
    e.chan = ch;
    if (!rst) begin
      exp_sticky = 6'd0;
      exp_count  = 16'd0;
    end else begin
      exp_sticky = exp_sticky | errs;
      if (errs != M_NONE) exp_count = exp_count + 16'd1;
    end
    e.sticky = exp_sticky;
    e.count  = exp_count;
    sb.push_back(e);
    @(negedge clk);
    check_out(name);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_sticky = 6'd0;
    exp_count  = 16'd0;
    for (int k = 0; k < 4; k++) exp_cov[k] = 16'd0;

    vecs[0]  = '{req: 4'b0000, gnt: 4'b0000, errs: M_NONE,          chan: 2'd0};
    vecs[1]  = '{req: 4'b1001, gnt: 4'b0000, errs: M_NONE,          chan: 2'd0};
    vecs[2]  = '{req: 4'b0001, gnt: 4'b1001, errs: M_ONE | M_NOREQ, chan: 2'd0};
    vecs[3]  = '{req: 4'b0000, gnt: 4'b0000, errs: M_NONE,          chan: 2'd0};
    vecs[4]  = '{req: 4'b0000, gnt: 4'b0100, errs: M_NOREQ,         chan: 2'd2};
    vecs[5]  = '{req: 4'b0000, gnt: 4'b0000, errs: M_NONE,          chan: 2'd0};
    vecs[6]  = '{req: 4'b0110, gnt: 4'b0110, errs: M_ONE,           chan: 2'd0};
    vecs[7]  = '{req: 4'b0110, gnt: 4'b0000, errs: M_SHORT,         chan: 2'd1};
    vecs[8]  = '{req: 4'b0000, gnt: 4'b0000, errs: M_NONE,          chan: 2'd0};
    vecs[9]  = '{req: 4'b1000, gnt: 4'b1010, errs: M_ONE | M_NOREQ, chan: 2'd0};
    vecs[10] = '{req: 4'b0000, gnt: 4'b0000, errs: M_NONE,          chan: 2'd0};
    vecs[11] = '{req: 4'b0010, gnt: 4'b1000, errs: M_NOREQ,         chan: 2'd3};
    vecs[12] = '{req: 4'b0010, gnt: 4'b0000, errs: M_NONE,          chan: 2'd0};
    vecs[13] = '{req: 4'b0000, gnt: 4'b0000, errs: M_NONE,          chan: 2'd0};

    reset = 1'b0;
    req   = 4'b0000;
    gnt   = 4'b0000;
    @(negedge clk);

    repeat (3) step(1'b0, 4'b0000, 4'b0000, M_NONE, 2'd0, "reset");
    cmp("reset", "gnt_cov", gnt_cov[31:0] | gnt_cov[63:32], 32'd0);
    step(1'b1, 4'b0010, 4'b0010, M_RST, 2'd0, "rst_exit");
    step(1'b1, 4'b0000, 4'b0000, M_NONE, 2'd0, "rst_exit_rel");

    for (int i = 0; i < 14; i++) begin
      step(1'b1, vecs[i].req, vecs[i].gnt, vecs[i].errs, vecs[i].chan, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a held grant must clear the FSM (no short after release)
    repeat (3) step(1'b1, 4'b0100, 4'b0100, M_NONE, 2'd0, "midrst_hold");
    repeat (2) step(1'b0, 4'b0100, 4'b0100, M_NONE, 2'd0, "midrst_in");
    step(1'b1, 4'b0100, 4'b0000, M_NONE, 2'd0, "midrst_exit");
    step(1'b1, 4'b0000, 4'b0000, M_NONE, 2'd0, "midrst_idle");

    repeat (16) step(1'b1, 4'b0100, 4'b0100, M_NONE, 2'd0, "full_hold");
    step(1'b1, 4'b0000, 4'b0000, M_NONE, 2'd0, "full_drop");
`ifdef ARB_MON_COVER_EN
    exp_cov[2] = 16'd1;
`endif
    cmp("full_grant", "gnt_cov2", 32'(gnt_cov[47:32]), 32'(exp_cov[2]));

    repeat (15) step(1'b1, 4'b0100, 4'b0100, M_NONE, 2'd0, "len15_hold");
    step(1'b1, 4'b0100, 4'b0000, M_SHORT, 2'd2, "len15_drop");
    step(1'b1, 4'b0000, 4'b0000, M_NONE, 2'd0, "len15_idle");

    repeat (9) step(1'b1, 4'b0010, 4'b0010, M_NONE, 2'd0, "short_hold");
    step(1'b1, 4'b0010, 4'b0000, M_SHORT, 2'd1, "short_drop");
    step(1'b1, 4'b0000, 4'b0000, M_NONE, 2'd0, "short_idle");

    repeat (16) step(1'b1, 4'b0001, 4'b0001, M_NONE, 2'd0, "ovr_hold");
    step(1'b1, 4'b1001, 4'b0001, M_OVR, 2'd0, "ovr_first");
    repeat (3) step(1'b1, 4'b1001, 4'b0001, M_NONE, 2'd0, "ovr_again");
    step(1'b1, 4'b0000, 4'b0000, M_NONE, 2'd0, "ovr_drop");
`ifdef ARB_MON_COVER_EN
    exp_cov[0] = 16'd1;
`endif

    for (int i = 1; i <= 70; i++) begin
      step(1'b1, 4'b1000, 4'b0000, (i == 64) ? M_STV : M_NONE, 2'd3, $sformatf("starve%0d", i));
    end
    step(1'b1, 4'b0000, 4'b0000, M_NONE, 2'd0, "starve_clr");

    for (int k = 0; k < 4; k++) begin
      cmp($sformatf("cov%0d", k), "gnt_cov", 32'(gnt_cov[k*16 +: 16]), 32'(exp_cov[k]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
